// File: rtl/vga_mode_sched.sv
// Video mode scheduler: swaps the timing generator's mode at a frame boundary
// with a held reset and blanking window. Define VGA_MODE_SETTLE_EN to add post-reset settle frames.
module vga_mode_sched #(
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_FRAMES = 2,
    parameter int FRAME_TIMEOUT = 4194304
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic [2:0]  req_mode,
    output logic        req_ready,
    input  logic        frame_start,
    output logic        vtc_rstn,
    output logic        blank,
    output logic [11:0] h_active,
    output logic [11:0] h_fp,
    output logic [11:0] h_sync,
    output logic [11:0] h_bp,
    output logic [10:0] v_active,
    output logic [10:0] v_fp,
    output logic [10:0] v_sync,
    output logic [10:0] v_bp,
    output logic        h_pol,
    output logic        v_pol,
    output logic [2:0]  cur_mode,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {RUN, WAIT_FRAME, HOLD, SETTLE, RST_INIT} state_t;

    localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam logic [22:0] TO_LAST   = 23'(FRAME_TIMEOUT - 1);
`ifdef VGA_MODE_SETTLE_EN
    localparam logic [3:0]  SF_LAST   = 4'(SETTLE_FRAMES - 1);
`endif

    // {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}
    function automatic logic [91:0] mode_timing(input logic [2:0] m);
        case (m)
            3'd1:    return {12'd800,  12'd40,  12'd128, 12'd88,  11'd600,  11'd1,  11'd4, 11'd23};
            3'd2:    return {12'd1024, 12'd24,  12'd136, 12'd160, 11'd768,  11'd3,  11'd6, 11'd29};
            3'd3:    return {12'd1280, 12'd110, 12'd40,  12'd220, 11'd720,  11'd5,  11'd5, 11'd20};
            3'd4:    return {12'd1280, 12'd48,  12'd112, 12'd248, 11'd1024, 11'd1,  11'd3, 11'd38};
            3'd5:    return {12'd1680, 12'd48,  12'd32,  12'd80,  11'd1050, 11'd3,  11'd6, 11'd21};
            3'd6:    return {12'd1920, 12'd88,  12'd44,  12'd148, 11'd1080, 11'd4,  11'd5, 11'd36};
            default: return {12'd640,  12'd16,  12'd96,  12'd48,  11'd480,  11'd10, 11'd2, 11'd33};
        endcase
    endfunction

    state_t      state_q;
    logic        vtc_rstn_q, blank_q, ready_q, busy_q, done_q, err_q, init_q;
    logic [2:0]  mode_q, new_mode_q;
    logic [91:0] timing_q;
    logic [7:0]  hold_cnt_q;
    logic [22:0] to_cnt_q;
`ifdef VGA_MODE_SETTLE_EN
    logic [3:0]  frame_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= RST_INIT;
            vtc_rstn_q  <= 1'b0;
            blank_q     <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            init_q      <= 1'b1;
            mode_q      <= 3'd0;
            new_mode_q  <= 3'd0;
            timing_q    <= mode_timing(3'd0);
            hold_cnt_q  <= 8'd0;
            to_cnt_q    <= 23'd0;
`ifdef VGA_MODE_SETTLE_EN
            frame_cnt_q <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                // Reset already loaded mode 0 and asserted blank/vtc reset; just start the hold count.
                RST_INIT: begin
                    hold_cnt_q <= HOLD_LAST;
                    state_q    <= HOLD;
                end
                RUN: begin
                    if (req_valid && ready_q) begin
                        if (req_mode == 3'd7) begin
                            err_q <= 1'b1;
                        end else if (req_mode == mode_q) begin
                            done_q <= 1'b1;
                        end else begin
                            new_mode_q <= req_mode;
                            to_cnt_q   <= 23'd0;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b0;
                            state_q    <= WAIT_FRAME;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start || to_cnt_q >= TO_LAST) begin
                        state_q    <= HOLD;
                        blank_q    <= 1'b1;
                        vtc_rstn_q <= 1'b0;
                        mode_q     <= new_mode_q;
                        timing_q   <= mode_timing(new_mode_q);
                        hold_cnt_q <= HOLD_LAST;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + 23'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == 8'd0) begin
                        vtc_rstn_q <= 1'b1;
`ifdef VGA_MODE_SETTLE_EN
                        frame_cnt_q <= 4'd0;
                        state_q     <= SETTLE;
`else
                        state_q <= RUN;
                        blank_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= !init_q;
                        init_q  <= 1'b0;
`endif
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
`ifdef VGA_MODE_SETTLE_EN
                    // Only frames from the released generator count; HOLD never reaches here.
                    if (frame_start) begin
                        if (frame_cnt_q == SF_LAST) begin
                            state_q <= RUN;
                            blank_q <= 1'b0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            done_q  <= !init_q;
                            init_q  <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 4'd1;
                        end
                    end
`else
                    state_q <= RUN;
`endif
                end
                default: state_q <= RST_INIT;
            endcase
        end
    end

    assign req_ready = ready_q;
    assign vtc_rstn  = vtc_rstn_q;
    assign blank     = blank_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cur_mode  = mode_q;
    assign {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp} = timing_q;
    assign h_pol     = 1'b0;
    assign v_pol     = 1'b0;

endmodule

// File: tb/tb_vga_mode_sched.sv
// Bench for vga_mode_sched: per-cycle comparison against a phase/counter model of the
// mode-change sequence, plus literal spot checks. Honours VGA_MODE_SETTLE_EN like the DUT.
module tb_vga_mode_sched;

    localparam int RC = 16;
    localparam int SF = 2;
    localparam int FT = 300;
`ifdef VGA_MODE_SETTLE_EN
    localparam bit SETTLE_EN = 1'b1;
`else
    localparam bit SETTLE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0, req_valid = 1'b0, frame_start = 1'b0;
    logic [2:0]  req_mode = 3'd0;
    logic        req_ready, vtc_rstn, blank, h_pol, v_pol, busy, done, err;
    logic [11:0] h_active, h_fp, h_sync, h_bp;
    logic [10:0] v_active, v_fp, v_sync, v_bp;
    logic [2:0]  cur_mode;

    vga_mode_sched #(.RESET_CYCLES(RC), .SETTLE_FRAMES(SF), .FRAME_TIMEOUT(FT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_mode(req_mode),
        .req_ready(req_ready), .frame_start(frame_start), .vtc_rstn(vtc_rstn),
        .blank(blank), .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
        .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
        .h_pol(h_pol), .v_pol(v_pol), .cur_mode(cur_mode), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int HT [0:6][0:3] = '{'{640,16,96,48}, '{800,40,128,88}, '{1024,24,136,160},
                          '{1280,110,40,220}, '{1280,48,112,248}, '{1680,48,32,80},
                          '{1920,88,44,148}};
    int VT [0:6][0:3] = '{'{480,10,2,33}, '{600,1,4,23}, '{768,3,6,29}, '{720,5,5,20},
                          '{1024,1,3,38}, '{1050,3,6,21}, '{1080,4,5,36}};

    // Model: the phase of the mode change plus counters measured in edges/pulses.
    localparam int P_RUN = 0, P_WAIT = 1, P_HOLD = 2, P_SETTLE = 3, P_INIT = 4;
    int ph = P_INIT, m_mode = 0, pend = 0, waited = 0, left = 0, frames = 0;
    bit first = 1'b1, m_done = 1'b0, m_err = 1'b0;
    int n_checks = 0, n_errors = 0;

    task automatic finish_run();
        ph = P_RUN;
        m_done = !first;
        first = 1'b0;
    endtask

    task automatic model_step();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rstn) begin
            ph = P_INIT; m_mode = 0; first = 1'b1;
        end else begin
            case (ph)
                P_INIT: begin ph = P_HOLD; left = RC; end
                P_RUN: if (req_valid) begin
                    if (req_mode == 3'd7) m_err = 1'b1;
                    else if (int'(req_mode) == m_mode) m_done = 1'b1;
                    else begin pend = int'(req_mode); waited = 0; ph = P_WAIT; end
                end
                P_WAIT: begin
                    waited++;
                    if (frame_start || waited == FT) begin
                        ph = P_HOLD; m_mode = pend; left = RC;
                    end
                end
                P_HOLD: begin
                    left--;
                    if (left == 0) begin
                        if (SETTLE_EN) begin ph = P_SETTLE; frames = 0; end
                        else finish_run();
                    end
                end
                P_SETTLE: if (frame_start) begin
                    frames++;
                    if (frames == SF) finish_run();
                end
                default: ph = P_INIT;
            endcase
        end
    endtask

    function automatic logic [102:0] exp_vec();
        logic vtc_e, blank_e;
        vtc_e   = (ph == P_RUN || ph == P_WAIT || ph == P_SETTLE);
        blank_e = (ph == P_INIT || ph == P_HOLD || ph == P_SETTLE);
        return {vtc_e, blank_e, ph == P_RUN, ph != P_RUN, m_done, m_err, 3'(m_mode),
                12'(HT[m_mode][0]), 12'(HT[m_mode][1]), 12'(HT[m_mode][2]), 12'(HT[m_mode][3]),
                11'(VT[m_mode][0]), 11'(VT[m_mode][1]), 11'(VT[m_mode][2]), 11'(VT[m_mode][3]),
                2'b00};
    endfunction

    function automatic logic [102:0] dut_vec();
        return {vtc_rstn, blank, req_ready, busy, done, err, cur_mode,
                h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, h_pol, v_pol};
    endfunction

    task automatic tick();
        logic [102:0] e, a;
        model_step();
        @(posedge clk);
        #1;
        e = exp_vec();
        a = dut_vec();
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL outputs t=%0t dut=%h model=%h", $time, a, e);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, expv);
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Bounded wait for the generator release, then the settle frames when enabled.
    task automatic complete_change();
        for (int i = 0; i < 4 * RC && !vtc_rstn; i++) tick();
        check_lit("vtc_release", int'(vtc_rstn), 1);
`ifdef VGA_MODE_SETTLE_EN
        repeat (SF) begin
            repeat (4) tick();
            pulse_fs();
        end
`endif
        check_lit("back_to_run", int'(req_ready), 1);
    endtask

    initial begin
        // Reset values
        repeat (3) tick();
        check_lit("rst_blank", int'(blank), 1);
        check_lit("rst_vtc", int'(vtc_rstn), 0);
        check_lit("rst_busy", int'(busy), 1);
        check_lit("rst_h_active", int'(h_active), 640);

        // Power-up sequence for mode 0
        rstn = 1'b1;
        repeat (16) tick();
        check_lit("init_vtc_edge15", int'(vtc_rstn), 0);
        tick();
        check_lit("init_vtc_edge16", int'(vtc_rstn), 1);
`ifdef VGA_MODE_SETTLE_EN
        repeat (5) tick();
        pulse_fs();
        check_lit("init_blank_1st", int'(blank), 1);
        repeat (5) tick();
        pulse_fs();
`endif
        check_lit("init_blank", int'(blank), 0);
        check_lit("init_ready", int'(req_ready), 1);
        check_lit("init_no_done", int'(done), 0);
        check_lit("init_h_active", int'(h_active), 640);

        // Mode 6 with a frame boundary 100 cycles after acceptance
        req_valid = 1'b1; req_mode = 3'd6;
        tick();
        req_valid = 1'b0;
        check_lit("m6_busy", int'(busy), 1);
        check_lit("m6_blank_wait", int'(blank), 0);
        repeat (99) tick();
        pulse_fs();
        check_lit("m6_blank", int'(blank), 1);
        check_lit("m6_vtc", int'(vtc_rstn), 0);
        check_lit("m6_h_active", int'(h_active), 1920);
        check_lit("m6_v_bp", int'(v_bp), 36);
        repeat (RC) tick();
        check_lit("m6_vtc_up", int'(vtc_rstn), 1);
`ifdef VGA_MODE_SETTLE_EN
        repeat (3) tick();
        pulse_fs();
        check_lit("m6_no_done_yet", int'(done), 0);
        repeat (3) tick();
        pulse_fs();
`endif
        check_lit("m6_done", int'(done), 1);
        check_lit("m6_cur_mode", int'(cur_mode), 6);
        tick();
        check_lit("m6_done_pulse", int'(done), 0);

        // Reserved mode and same-mode requests
        req_valid = 1'b1; req_mode = 3'd7;
        tick();
        check_lit("m7_err", int'(err), 1);
        check_lit("m7_ready", int'(req_ready), 1);
        check_lit("m7_h_active", int'(h_active), 1920);
        req_mode = 3'd6;
        tick();
        check_lit("same_err_clear", int'(err), 0);
        check_lit("same_done", int'(done), 1);
        req_valid = 1'b0;
        tick();

        // Mode 3 via timeout; other requests held during WAIT_FRAME and HOLD
        req_valid = 1'b1; req_mode = 3'd3;
        tick();
        req_mode = 3'd5;
        repeat (FT - 1) tick();
        check_lit("to_still_wait", int'(blank), 0);
        tick();
        check_lit("to_hold", int'(blank), 1);
        check_lit("to_h_sync", int'(h_sync), 40);
        repeat (RC - 1) begin
            req_mode = 3'($urandom_range(0, 6));
            tick();
        end
        req_valid = 1'b0;
        complete_change();
        check_lit("held_req_mode", int'(cur_mode), 3);

        // Reset in the middle of HOLD for mode 4
        req_valid = 1'b1; req_mode = 3'd4;
        tick();
        req_valid = 1'b0;
        pulse_fs();
        check_lit("m4_cur_mode", int'(cur_mode), 4);
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        check_lit("abort_cur_mode", int'(cur_mode), 0);
        check_lit("abort_blank", int'(blank), 1);
        check_lit("abort_h_active", int'(h_active), 640);
        rstn = 1'b1;
        complete_change();

        // Random traffic: dense frames first, then sparse frames to reach timeouts
        for (int i = 0; i < 5000; i++) begin
            rstn        = ($urandom_range(0, 999) != 0);
            req_valid   = ($urandom_range(0, 7) == 0);
            req_mode    = 3'($urandom_range(0, 7));
            frame_start = (i < 2500) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
